// File: rtl/gf_mult_ctrl_pkg.sv
// Shared types and constants for the GF(2^8) multiplier controller.
package gf_mult_ctrl_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Generator polynomial after reset: x^8 + x^4 + x^3 + x + 1 (x^8 implicit).
    localparam logic [7:0] G_DEFAULT = 8'h1B;

endpackage

// File: rtl/gf_mult_ctrl_if.sv
// Operand/result handshakes, configuration and multiplier-array bus.
//
// Handshake rule for both in_* and out_*: a transfer happens on a rising
// edge where valid && ready. A source may not retract or change its payload
// while valid && !ready; ready may depend combinationally on valid.
interface gf_mult_ctrl_if #(
    parameter int TAGW = 4
) ();
    logic            cfg_we;
    logic [7:0]      cfg_g;

    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_a;
    logic [7:0]      in_b;
    logic [TAGW-1:0] in_tag;

    logic [7:0]      arr_a;
    logic [7:0]      arr_b;
    logic [7:0]      arr_g;
    logic [7:0]      arr_p;

    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_p;
    logic [TAGW-1:0] out_tag;

    logic            busy;

    // Requester side: issues operands/config, consumes results, hosts the array.
    modport master (
        output cfg_we, cfg_g, in_valid, in_a, in_b, in_tag, arr_p, out_ready,
        input  in_ready, arr_a, arr_b, arr_g, out_valid, out_p, out_tag, busy
    );

    // Controller side.
    modport slave (
        input  cfg_we, cfg_g, in_valid, in_a, in_b, in_tag, arr_p, out_ready,
        output in_ready, arr_a, arr_b, arr_g, out_valid, out_p, out_tag, busy
    );
endinterface

// File: rtl/gf_res_fifo.sv
// Synchronous result FIFO (DEPTH must be a power of two, at least 2).
// Head entry is visible on o_rd_data whenever o_count is non-zero.
module gf_res_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr_en,
    input  logic [W-1:0]               i_wr_data,
    input  logic                       i_rd_en,
    output logic [W-1:0]               o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_rd;

    // A pop of an empty FIFO is ignored.
    assign w_rd = i_rd_en && (r_count != '0);

    // Storage and pointers; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous write and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({i_wr_en, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
endmodule

// File: rtl/gf_mult_ctrl.sv
// Controller for a free-running GF(2^8) multiplier array: credit-based
// operand acceptance, a valid/tag pipeline matching the array latency, an
// in-order result FIFO, and a drain-then-load sequence for new polynomials.
module gf_mult_ctrl
    import gf_mult_ctrl_pkg::*;
#(
    parameter int LAT   = 8,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    gf_mult_ctrl_if.slave bus,
    output state_t        o_dbg_state
);
    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]    DEPTH_C = DEPTH[CW:0];

    state_t          r_state;
    logic [7:0]      r_g;
    logic [7:0]      r_pend;
    logic [7:0]      r_arr_a;
    logic [7:0]      r_arr_b;
    // Stage 0 travels with arr_a/arr_b; stage LAT lines up with arr_p.
    logic [LAT:0]    r_vld;
    logic [TAGW-1:0] r_tag [LAT+1];
    logic [CW-1:0]   r_inflight;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_credit;
    logic [7+TAGW:0] w_rd_data;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_exit;
    logic            w_out_valid;
    logic            w_pop;

    // Credits: every accepted op holds a FIFO slot until it is popped.
    assign w_credit    = {1'b0, r_inflight} + {1'b0, w_count};
    assign w_in_ready  = (r_state == RUN) && !bus.cfg_we && (w_credit < DEPTH_C);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_exit      = r_vld[LAT];
    assign w_out_valid = (w_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;

    // FSM: drain all work before committing a new polynomial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_g     <= G_DEFAULT;
            r_pend  <= G_DEFAULT;
        end else begin
            if (bus.cfg_we) r_pend <= bus.cfg_g;
            case (r_state)
                RUN:     if (bus.cfg_we) r_state <= DRAIN;
                DRAIN:   if (r_inflight == '0 && w_count == '0) r_state <= LOAD;
                LOAD: begin
                    r_g     <= r_pend;
                    r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // Operand registers feed the array; they hold on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arr_a <= '0;
            r_arr_b <= '0;
        end else if (w_accept) begin
            r_arr_a <= bus.in_a;
            r_arr_b <= bus.in_b;
        end
    end

    // Valid/tag pipeline shifts every cycle alongside the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i <= LAT; i++) r_tag[i] <= '0;
        end else begin
            r_vld    <= {r_vld[LAT-1:0], w_accept};
            r_tag[0] <= bus.in_tag;
            for (int i = 1; i <= LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    // Operations between acceptance and FIFO write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_exit})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    gf_res_fifo #(
        .DEPTH (DEPTH),
        .W     (8 + TAGW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_exit),
        .i_wr_data ({bus.arr_p, r_tag[LAT]}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_count   (w_count)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.arr_a     = r_arr_a;
    assign bus.arr_b     = r_arr_b;
    assign bus.arr_g     = r_g;
    assign bus.out_valid = w_out_valid;
    assign bus.out_p     = w_rd_data[7+TAGW:TAGW];
    assign bus.out_tag   = w_rd_data[TAGW-1:0];
    assign bus.busy      = (r_state != RUN) || (r_inflight != '0) || (w_count != '0);
    assign o_dbg_state   = r_state;
endmodule
